// File: rtl/mulu_x3y3_stage_pkg.sv
// rtl/mulu_x3y3_stage_pkg.sv - shared widths, depth and constants for the 3x3 multiplier stage
package mulu_x3y3_stage_pkg;

    localparam int X_WIDTH_DEF = 3;
    localparam int Y_WIDTH_DEF = 3;
    localparam int P_WIDTH_DEF = X_WIDTH_DEF + Y_WIDTH_DEF;
    localparam int DEPTH_DEF   = 4;

    localparam logic READY_TRUE = 1'b1;

    // Occupancy needs one bit more than the pointers so "full" is representable.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mulu_result_fifo.sv
// rtl/mulu_result_fifo.sv - synchronous result FIFO with push/pop/count, async active-high reset
module mulu_result_fifo
    import mulu_x3y3_stage_pkg::*;
#(
    parameter int WIDTH = P_WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
)
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_push,
    input  logic [WIDTH-1:0]                i_push_data,
    input  logic                            i_pop,
    output logic [WIDTH-1:0]                o_head,
    output logic                            o_not_empty,
    output logic [count_width(DEPTH)-1:0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;

    assign o_not_empty = (r_count != '0);
    assign w_pop       = i_pop & o_not_empty;
    assign o_head      = r_mem[r_rptr];
    assign o_count     = r_count;

    // Pointers are log2(DEPTH) bits wide, so wrap-around is free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_push_data;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mulu_x3y3_stage.sv
// rtl/mulu_x3y3_stage.sv - registered operand/result stage around the 3x3 multiplier core; MULU_STAGE_SIGN_EN adds out_s
module mulu_x3y3_stage
    import mulu_x3y3_stage_pkg::*;
#(
    parameter int X_WIDTH = X_WIDTH_DEF,
    parameter int Y_WIDTH = Y_WIDTH_DEF,
    parameter int P_WIDTH = P_WIDTH_DEF,
    parameter int DEPTH   = DEPTH_DEF
)
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic [X_WIDTH-1:0]              in_x,
    input  logic [Y_WIDTH-1:0]              in_y,
    output logic                            in_ready,
    output logic [X_WIDTH-1:0]              core_x,
    output logic [Y_WIDTH-1:0]              core_y,
    input  logic [P_WIDTH-1:0]              core_p,
    output logic                            out_valid,
    output logic [P_WIDTH-1:0]              out_p,
    input  logic                            out_ready,
`ifdef MULU_STAGE_SIGN_EN
    output logic                            out_s,
`endif
    output logic [count_width(DEPTH)-1:0]   count
);

    localparam int CW = count_width(DEPTH);
`ifdef MULU_STAGE_SIGN_EN
    localparam int FW = P_WIDTH + 1;
`else
    localparam int FW = P_WIDTH;
`endif
    localparam logic [CW:0] DEPTH_LIM = DEPTH[CW:0];

    logic [X_WIDTH-1:0] r_core_x;
    logic [Y_WIDTH-1:0] r_core_y;
    logic               r_inflight;
    logic               w_accept;
    logic [CW:0]        w_occupancy;
    logic [FW-1:0]      w_push_data;
    logic [FW-1:0]      w_head;

    // The in-flight product already owns a slot, so a capture can never overflow.
    assign w_occupancy = {1'b0, count} + {{CW{1'b0}}, r_inflight};
    assign in_ready    = (w_occupancy < DEPTH_LIM) ? READY_TRUE : ~READY_TRUE;
    assign w_accept    = in_valid & in_ready;

    assign core_x = r_core_x;
    assign core_y = r_core_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_core_x   <= '0;
            r_core_y   <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_accept;
            if (w_accept) begin
                r_core_x <= in_x;
                r_core_y <= in_y;
            end
        end
    end

`ifdef MULU_STAGE_SIGN_EN
    logic r_sign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sign <= 1'b0;
        end else if (w_accept) begin
            r_sign <= in_x[X_WIDTH-1] ^ in_y[Y_WIDTH-1];
        end
    end

    assign w_push_data = {r_sign, core_p};
    assign out_s       = w_head[FW-1];
    assign out_p       = w_head[P_WIDTH-1:0];
`else
    assign w_push_data = core_p;
    assign out_p       = w_head;
`endif

    mulu_result_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_inflight),
        .i_push_data (w_push_data),
        .i_pop       (out_ready),
        .o_head      (w_head),
        .o_not_empty (out_valid),
        .o_count     (count)
    );

endmodule

// File: tb/tb_mulu_x3y3_stage.sv
// tb/tb_mulu_x3y3_stage.sv - bench for mulu_x3y3_stage against a queue-based reference model
module tb_mulu_x3y3_stage;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [2:0] in_x;
    logic [2:0] in_y;
    logic       in_ready;
    logic [2:0] core_x;
    logic [2:0] core_y;
    logic [5:0] core_p;
    logic       out_valid;
    logic [5:0] out_p;
    logic       out_ready;
    logic [2:0] count;
`ifdef MULU_STAGE_SIGN_EN
    logic       out_s;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model: queued entries are product | (sign << 6).
    int unsigned q[$];
    bit          m_inflight;
    int unsigned m_pend;
    int unsigned m_x;
    int unsigned m_y;

    always #5 clk = ~clk;

    // Stand-in for the combinational multiplier core owned by the parent.
    assign core_p = core_x * core_y;

    mulu_x3y3_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_ready  (in_ready),
        .core_x    (core_x),
        .core_y    (core_y),
        .core_p    (core_p),
        .out_valid (out_valid),
        .out_p     (out_p),
        .out_ready (out_ready),
`ifdef MULU_STAGE_SIGN_EN
        .out_s     (out_s),
`endif
        .count     (count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready();
        return (q.size() + int'(m_inflight)) < DEPTH;
    endfunction

    task automatic model_reset();
        q.delete();
        m_inflight = 1'b0;
        m_pend     = 0;
        m_x        = 0;
        m_y        = 0;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".in_ready"},  in_ready,  32'(model_ready()));
        check({tag, ".out_valid"}, out_valid, 32'(q.size() != 0));
        check({tag, ".count"},     count,     q.size());
        check({tag, ".core_x"},    core_x,    m_x);
        check({tag, ".core_y"},    core_y,    m_y);
        if (q.size() != 0) begin
            check({tag, ".out_p"}, out_p, q[0] & 32'h3f);
`ifdef MULU_STAGE_SIGN_EN
            check({tag, ".out_s"}, out_s, q[0] >> 6);
`endif
        end
    endtask

    // One rising edge: predict from the pre-edge inputs, then compare #1 after.
    task automatic step(input string tag);
        bit          acc;
        bit          pop;
        int unsigned sgn;
        acc = in_valid && model_ready();
        pop = (q.size() != 0) && out_ready;
        sgn = ((int'(in_x) >> 2) & 1) ^ ((int'(in_y) >> 2) & 1);
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (m_inflight) q.push_back(m_pend);
        m_inflight = acc;
        if (acc) begin
            m_x    = in_x;
            m_y    = in_y;
            m_pend = (m_x * m_y) | (sgn << 6);
        end
        #1;
        compare_all(tag);
    endtask

    int unsigned fx[5] = '{7, 1, 2, 3, 4};
    int unsigned fy[5] = '{7, 3, 2, 5, 4};
    int unsigned drain_exp[4] = '{49, 3, 4, 15};

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset.out_p", out_p, 0);
        compare_all("reset");

        // Single operation, downstream stalled.
        in_valid = 1'b1; in_x = 3'd5; in_y = 3'd6;
        step("single1");
        check("single.core_x", core_x, 5);
        check("single.core_y", core_y, 6);
        in_valid = 1'b0;
        step("single2");
        check("single.out_p", out_p, 30);
        check("single.count", count, 1);
        out_ready = 1'b1;
        step("single_drain");
        out_ready = 1'b0;

        // Fill and stall: present each pair until taken; (4,4) must never be taken.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_x = fx[i][2:0]; in_y = fy[i][2:0];
            for (int t = 0; t < 4; t++) begin
                bit was_ready;
                was_ready = model_ready();
                step("fill");
                if (was_ready) break;
            end
        end
        in_valid = 1'b0;
        check("fill.count", count, 4);
        check("fill.in_ready", in_ready, 0);

        // Drain order.
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("drain.out_p", out_p, drain_exp[k]);
            step("drain");
        end
        check("drain.out_valid", out_valid, 0);
        check("drain.count", count, 0);

        // Streaming at one product per cycle.
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_x = 3'($urandom_range(0, 7));
            in_y = 3'($urandom_range(0, 7));
            step("stream");
            check("stream.count_le1", 32'(count <= 3'd1), 1);
            if (i >= 1) check("stream.out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        step("stream_tail1");
        step("stream_tail2");
        out_ready = 1'b0;

        // Reset while a product is in flight.
        in_valid = 1'b1; in_x = 3'd4; in_y = 3'd7;
        step("midrst_acc");
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("midrst.out_valid", out_valid, 0);
        check("midrst.count", count, 0);
        check("midrst.core_x", core_x, 0);
        check("midrst.core_y", core_y, 0);
        check("midrst.in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("post_rst1");
        step("post_rst2");

        in_valid = 1'b1; in_x = 3'd4; in_y = 3'd3;
        step("sign_a");
        in_x = 3'd3; in_y = 3'd3;
        step("sign_b");
        in_valid = 1'b0;
        step("sign_c");
        check("sign.out_p_12", out_p, 12);
`ifdef MULU_STAGE_SIGN_EN
        check("sign.out_s_1", out_s, 1);
`endif
        out_ready = 1'b1;
        step("sign_pop");
        check("sign.out_p_9", out_p, 9);
`ifdef MULU_STAGE_SIGN_EN
        check("sign.out_s_0", out_s, 0);
`endif
        step("sign_drain");

        // Random handshakes on both sides, exercising pointer wrap and backpressure.
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_x = 3'($urandom_range(0, 7));
            in_y = 3'($urandom_range(0, 7));
            step("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
